// File: rtl/fp8_pkg.sv
// Shared definitions for the sequential FP8 divider: format fields,
// special encodings and the controller state type.
package fp8_pkg;

    localparam int EXP_BIAS = 7;
    localparam int FP8_W    = 8;
    localparam int EXP_W    = 4;
    localparam int MANT_W   = 3;
    localparam int QUOT_W   = MANT_W + 2;

    localparam logic [7:0] FP8_NAN  = 8'h7F;
    localparam logic [6:0] FP8_INF  = 7'h78;
    localparam logic [6:0] FP8_ZERO = 7'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        NORM   = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/fp8_mant_divider.sv
// Iterative restoring divider for the 4-bit significands {1,mant}.
// One quotient bit per cycle, MSB first; five bits after a start pulse,
// giving q = floor(({1,a_mant} << 4) / {1,b_mant}).
module fp8_mant_divider
    import fp8_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MANT_W-1:0] a_mant,
    input  logic [MANT_W-1:0] b_mant,
    output logic              busy,
    output logic              done,
    output logic [QUOT_W-1:0] q
);

    logic [4:0] rem_q;
    logic [4:0] rem_d;
    logic [4:0] div_q;
    logic [4:0] quo_q;
    logic [2:0] cnt_q;
    logic       busy_q;
    logic       done_q;
    logic       ge_s;
    logic [4:0] diff_s;

    // One restoring step: compare, conditionally subtract, shift left.
    // The remainder after a subtract is below the divisor (<= 14), so the
    // shifted value always fits in five bits.
    always_comb begin
        ge_s   = (rem_q >= div_q);
        diff_s = rem_q;
        if (ge_s) begin
            diff_s = rem_q - div_q;
        end else begin
            diff_s = rem_q;
        end
        rem_d = {diff_s[3:0], 1'b0};
    end

    // Iteration registers: load on start, step while busy, flag completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= 5'd0;
            div_q  <= 5'd0;
            quo_q  <= 5'd0;
            cnt_q  <= 3'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (start) begin
            rem_q  <= {2'b01, a_mant};
            div_q  <= {2'b01, b_mant};
            quo_q  <= 5'd0;
            cnt_q  <= 3'd0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else if (busy_q) begin
            rem_q  <= rem_d;
            quo_q  <= {quo_q[3:0], ge_s};
            cnt_q  <= cnt_q + 3'd1;
            if (cnt_q == 3'd4) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end else begin
                busy_q <= 1'b1;
                done_q <= 1'b0;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign q    = quo_q;

endmodule

// File: rtl/fp8_divider_seq.sv
// Sequential FP8 (1/4/3, bias 7) divider with valid/ready handshakes.
// Special operands resolve straight to DONE; normal operands go through
// five DIVIDE cycles in the mantissa divider and one NORM cycle.
module fp8_divider_seq
    import fp8_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] quotient
);

    localparam logic signed [5:0] BIAS_S = 6'(EXP_BIAS);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  quot_q, quot_d;
    logic        out_valid_q;
    logic        s_q, s_d;
    logic [3:0]  ea_q, ea_d;
    logic [3:0]  eb_q, eb_d;

    logic        nan_a_s, nan_b_s, inf_a_s, inf_b_s, zero_a_s, zero_b_s;
    logic        special_s;
    logic        sign_s;
    logic        transfer_s;
    logic        in_ready_s;
    logic        div_start_s;
    logic        div_busy_s;
    logic        div_done_s;
    logic [4:0]  div_q_s;
    logic [7:0]  special_res_s;
    logic [7:0]  norm_res_s;
    logic signed [5:0] exp_s;
    logic [2:0]  mant_s;

    // Priority-ordered result for operand pairs containing a special value.
    function automatic logic [7:0] special_result(
        input logic s,
        input logic nan_a, input logic nan_b,
        input logic inf_a, input logic inf_b,
        input logic zero_a, input logic zero_b
    );
        if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
            return FP8_NAN;
        end else if (inf_a || zero_b) begin
            return {s, FP8_INF};
        end else if (zero_a || inf_b) begin
            return {s, FP8_ZERO};
        end else begin
            return {s, FP8_ZERO};
        end
    endfunction

    fp8_mant_divider u_mant_div (
        .clk    (clk),
        .rst    (rst),
        .start  (div_start_s),
        .a_mant (a[2:0]),
        .b_mant (b[2:0]),
        .busy   (div_busy_s),
        .done   (div_done_s),
        .q      (div_q_s)
    );

    // Operand classification; subnormals are treated as zero.
    always_comb begin
        nan_a_s   = (a[6:3] == 4'hF) && (a[2:0] != 3'd0);
        nan_b_s   = (b[6:3] == 4'hF) && (b[2:0] != 3'd0);
        inf_a_s   = (a[6:3] == 4'hF) && (a[2:0] == 3'd0);
        inf_b_s   = (b[6:3] == 4'hF) && (b[2:0] == 3'd0);
        zero_a_s  = (a[6:3] == 4'h0);
        zero_b_s  = (b[6:3] == 4'h0);
        special_s = nan_a_s | nan_b_s | inf_a_s | inf_b_s | zero_a_s | zero_b_s;
        sign_s    = a[7] ^ b[7];
        special_res_s = special_result(sign_s, nan_a_s, nan_b_s, inf_a_s,
                                       inf_b_s, zero_a_s, zero_b_s);
    end

    // Normalise the 5-bit quotient, rebias the exponent, saturate, truncate.
    always_comb begin
        if (div_q_s[4]) begin
            mant_s = div_q_s[3:1];
            exp_s  = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + BIAS_S;
        end else begin
            mant_s = div_q_s[2:0];
            exp_s  = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + BIAS_S - 6'sd1;
        end
        if (exp_s >= 6'sd15) begin
            norm_res_s = {s_q, FP8_INF};
        end else if (exp_s <= 6'sd0) begin
            norm_res_s = {s_q, FP8_ZERO};
        end else begin
            norm_res_s = {s_q, exp_s[3:0], mant_s};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (transfer_s) begin
                    state_d = special_s ? DONE : DIVIDE;
                end else begin
                    state_d = IDLE;
                end
            end
            DIVIDE: begin
                if (cnt_q == 3'd4) begin
                    state_d = NORM;
                end else begin
                    state_d = DIVIDE;
                end
            end
            NORM: begin
                state_d = DONE;
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output and datapath control: handshake, divider start, step count,
    // operand capture and result selection.
    always_comb begin
        in_ready_s  = (state_q == IDLE) && !rst;
        transfer_s  = in_valid && in_ready_s;
        div_start_s = transfer_s && !special_s;
        if ((state_q == DIVIDE) && div_busy_s) begin
            cnt_d = cnt_q + 3'd1;
        end else begin
            cnt_d = 3'd0;
        end
        if (transfer_s) begin
            s_d  = sign_s;
            ea_d = a[6:3];
            eb_d = b[6:3];
        end else begin
            s_d  = s_q;
            ea_d = ea_q;
            eb_d = eb_q;
        end
        if (transfer_s && special_s) begin
            quot_d = special_res_s;
        end else if ((state_q == NORM) && div_done_s) begin
            quot_d = norm_res_s;
        end else begin
            quot_d = quot_q;
        end
    end

    // Datapath registers; out_valid tracks entry into DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= 3'd0;
            quot_q      <= 8'h00;
            out_valid_q <= 1'b0;
            s_q         <= 1'b0;
            ea_q        <= 4'd0;
            eb_q        <= 4'd0;
        end else begin
            cnt_q       <= cnt_d;
            quot_q      <= quot_d;
            out_valid_q <= (state_d == DONE);
            s_q         <= s_d;
            ea_q        <= ea_d;
            eb_q        <= eb_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign quotient  = quot_q;

endmodule

// File: doc/fp8_divider_seq.md
FP8_DIVIDER_SEQ -- requirements
Module: fp8_divider_seq

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The module SHALL have the port in_valid, input, 1 bit: a and b are valid.
REQ-004 The module SHALL have the port in_ready, output, 1 bit: the block accepts an operand pair.
REQ-005 The module SHALL have the port a, input, 8 bits: FP8 dividend as {sign[7], exponent[6:3], mantissa[2:0]}, with exponent bias 7.
REQ-006 The module SHALL have the port b, input, 8 bits: FP8 divisor, in the same format as a.
REQ-007 The module SHALL have the port out_valid, output, 1 bit: quotient is valid.
REQ-008 The module SHALL have the port out_ready, input, 1 bit: the consumer accepts the quotient.
REQ-009 The module SHALL have the port quotient, output, 8 bits: FP8 result of a / b.

Function
REQ-010 Operand classification SHALL be: exp=4'hF with mant!=0 is NaN; exp=4'hF with mant=0 is Inf; exp=0 is zero (subnormals flushed); any other value is normal.
REQ-011 An input transfer SHALL occur on the edge where in_valid && in_ready; in_ready SHALL be 1 only in state IDLE.
REQ-012 The FSM states SHALL be IDLE, DIVIDE, NORM and DONE.
REQ-013 Transitions from IDLE: on a transfer with a special case, go to DONE; on a transfer with two normal operands, go to DIVIDE.
REQ-014 DIVIDE SHALL run exactly 5 cycles, then go to NORM; NORM SHALL go to DONE after 1 cycle; DONE SHALL go to IDLE on out_valid && out_ready.
REQ-015 The divide step SHALL use restoring division with R initialised to {1,ma} and D={1,mb}, both 5 bits wide. Each DIVIDE cycle: q bit = (R>=D); if set, R=R-D; then R=R<<1. The 5 bits are collected MSB first into q[4:0], so q = floor(({1,ma}<<4)/{1,mb}).
REQ-016 Normalisation: if q[4]=1, mant=q[3:1] and e=ea-eb+7; otherwise mant=q[2:0] and e=ea-eb+6. e SHALL be computed as a signed value at least 6 bits wide. Rounding SHALL be truncation.
REQ-017 If e>=15 the result SHALL be {s,7'h78} (Inf). If e<=0 the result SHALL be {s,7'h00} (zero). Otherwise the result SHALL be {s,e[3:0],mant}. Here s=sa^sb.
REQ-018 Special-case results, in priority order: any NaN, 0/0 or Inf/Inf -> 8'h7F; Inf/x -> {s,7'h78}; x/0 -> {s,7'h78}; 0/x -> {s,7'h00}; x/Inf -> {s,7'h00}.
REQ-019 Latency: a normal operation SHALL assert out_valid 7 edges after its transfer edge. A special case SHALL assert out_valid 1 edge after its transfer edge.
REQ-020 In DONE, quotient and out_valid SHALL stay stable until out_ready is sampled high. in_valid SHALL be ignored outside IDLE.
REQ-021 out_valid SHALL be 1 only in DONE. Outside DONE, quotient SHALL hold its last value.
REQ-022 The block SHALL process one operation at a time; there is no input buffering.

Reset
REQ-023 When rst is high at a clock edge, the state SHALL become IDLE, the step counter 0, out_valid 0, quotient 8'h00 and in_ready 1 after the edge.
REQ-024 Reset mid-operation (DIVIDE, NORM or DONE) SHALL abort the operation with no output transfer. A held result SHALL be discarded.
REQ-025 in_ready SHALL be 0 in any cycle where rst is high.

Structure
REQ-026 A shared package fp8_pkg SHALL hold the following: EXP_BIAS=7, the field widths, the codes FP8_NAN=8'h7F, FP8_INF=7'h78 and FP8_ZERO=7'h00, and the FSM state enum.
REQ-027 One sub-module fp8_mant_divider SHALL hold the iterative 5-bit restoring mantissa divider. Its interface SHALL be start, a_mant, b_mant, busy, done and q[4:0].
REQ-028 Classification, special-case resolution, exponent arithmetic and the FSM SHALL reside in fp8_divider_seq.

Verification
REQ-029 Scenario: a=8'h44 (3.0), b=8'h3C (1.5), out_ready=1 -> quotient 8'h40 with out_valid 7 edges after transfer.
REQ-030 Scenario: a=8'h38, b=8'h3C -> quotient 8'h32 (truncated 0.625). Then a=8'hB8, b=8'h38 -> quotient 8'hB8.
REQ-031 Scenario: a=8'h77, b=8'h08 -> quotient 8'h78 (overflow). Then a=8'h08, b=8'h77 -> quotient 8'h00 (underflow).
REQ-032 Scenario: specials each give out_valid 1 edge after transfer: 00/00 -> 7F; 38/00 -> 78; B8/00 -> F8; 78/78 -> 7F; 39/78 -> 00.
REQ-033 Scenario: out_ready held 0 for 10 cycles in DONE -> quotient stable and in_ready=0 throughout; the transfer completes on the first out_ready=1.
REQ-034 Scenario: rst asserted during the 3rd DIVIDE cycle -> IDLE, out_valid=0, quotient=8'h00 after the edge. A new operation then completes with the correct result.
